array_max_scanner: RTL and testbench

Memory-mapped search engine that acts as the initiator on the data-memory port (address, write data, read enable, write enable, read data) normally driven by the pipeline MEM stage. On `start` it reads `len` consecutive 32-bit words from `base_adr`, tracks the largest signed value and its 0-based index, then writes the value to `RES_ADR` and the index to `RES_ADR+4`. It runs while the core is stalled or idle; arbitration with the core is external to this block.

---
 rtl/array_max_scanner_pkg.sv | 21 ++
 rtl/array_max_scanner_max_track.sv | 33 +++
 rtl/array_max_scanner.sv | 121 ++++++++++++
 tb/tb_array_max_scanner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/array_max_scanner_pkg.sv
// rtl/array_max_scanner_pkg.sv - shared states and constants for the array max scanner
package array_max_scanner_pkg;

   // 3-bit state encoding shared by the scanner FSM
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_WR_VAL = 3'd2,
      S_WR_IDX = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [31:0] RES_ADR_DEFAULT = 32'd2000;
   localparam logic [31:0] WORD_STRIDE     = 32'd4;

   // byte address of element idx of a word array starting at base (wraps at 32 bits)
   function automatic logic [31:0] word_adr(input logic [31:0] base, input logic [31:0] idx);
      return base + idx * WORD_STRIDE;
   endfunction

endpackage

// File: rtl/array_max_scanner_max_track.sv
// rtl/array_max_scanner_max_track.sv - signed running-maximum register with index
module max_track
   import array_max_scanner_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic             first,
   input  logic [31:0]      data,
   input  logic [LEN_W-1:0] idx,
   output logic [31:0]      max_val,
   output logic [LEN_W-1:0] max_idx
);

   logic load;

   // strict compare keeps the first occurrence on ties; first element always loads
   assign load = valid && (first || ($signed(data) > $signed(max_val)));

   // capture the new maximum and where it was found
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_val <= '0;
         max_idx <= '0;
      end else if (load) begin
         max_val <= data;
         max_idx <= idx;
      end
   end

endmodule

// File: rtl/array_max_scanner.sv
// rtl/array_max_scanner.sv - scans a word array in data memory and writes back its signed maximum
module array_max_scanner
   import array_max_scanner_pkg::*;
#(
   parameter logic [31:0] RES_ADR = RES_ADR_DEFAULT,
   parameter int          LEN_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      base_adr,
   input  logic [LEN_W-1:0] len,
   output logic [31:0]      mem_adr,
   output logic [31:0]      mem_wdata,
   output logic             mem_rd,
   output logic             mem_wr,
   input  logic [31:0]      mem_rdata,
   output logic             busy,
   output logic             done,
   output logic [31:0]      max_val,
   output logic [LEN_W-1:0] max_idx
);

   state_t           state;
   logic [31:0]      base_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] i;
   logic             last;

   assign last = (i == len_q - 1'b1);

   // sequencing, element counter and registered status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         base_q <= '0;
         len_q  <= '0;
         i      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  base_q <= base_adr;
                  len_q  <= len;
                  i      <= '0;
                  if (len != '0) begin
                     state <= S_READ;
                     busy  <= 1'b1;
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (last) state <= S_WR_VAL;
               else      i     <= i + 1'b1;
            end
            S_WR_VAL: begin
               state <= S_WR_IDX;
            end
            S_WR_IDX: begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // memory port decode; everything idles at zero outside the access states
   always_comb begin
      mem_adr   = '0;
      mem_wdata = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      case (state)
         S_READ: begin
            mem_rd  = 1'b1;
            mem_adr = word_adr(base_q, 32'(i));
         end
         S_WR_VAL: begin
            mem_wr    = 1'b1;
            mem_adr   = RES_ADR;
            mem_wdata = max_val;
         end
         S_WR_IDX: begin
            mem_wr    = 1'b1;
            mem_adr   = RES_ADR + WORD_STRIDE;
            mem_wdata = 32'(max_idx);
         end
         default: ;
      endcase
   end

   max_track #(
      .LEN_W(LEN_W)
   ) u_max_track (
      .clk     (clk),
      .rst     (rst),
      .valid   (state == S_READ),
      .first   (i == '0),
      .data    (mem_rdata),
      .idx     (i),
      .max_val (max_val),
      .max_idx (max_idx)
   );

endmodule

// File: tb/tb_array_max_scanner.sv
// tb/tb_array_max_scanner.sv - scoreboard bench for array_max_scanner
module tb_array_max_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_adr;
   logic [15:0] len;
   logic [31:0] mem_adr;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;
   logic [31:0] max_val;
   logic [15:0] max_idx;

   typedef struct {
      logic [31:0] val;
      logic [15:0] idx;
      int          lat;
      int          n;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] adr_q[$];
   logic [31:0] stim[$];
   logic [31:0] mem [0:1023];

   int n_pass  = 0;
   int n_total = 0;
   int rd_cnt  = 0;
   int wr_cnt  = 0;

   logic [31:0] model_val = '0;
   logic [15:0] model_idx = '0;

   localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

   always #5 clk = ~clk;

   array_max_scanner dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_adr  (base_adr),
      .len       (len),
      .mem_adr   (mem_adr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .done      (done),
      .max_val   (max_val),
      .max_idx   (max_idx)
   );

   // data memory: combinational read, write committed on posedge
   assign mem_rdata = mem[mem_adr[11:2]];

   always @(posedge clk) begin
      if (mem_wr) mem[mem_adr[11:2]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // bus monitor: read address order and rd/wr exclusivity
   always @(negedge clk) begin
      if (!rst && (mem_rd || mem_wr)) begin
         check("rd_wr_excl", 64'(mem_rd & mem_wr), 64'd0);
         if (mem_rd) begin
            rd_cnt++;
            if (adr_q.size() != 0) check("rd_adr", 64'(mem_adr), 64'(adr_q.pop_front()));
            else check("rd_extra", 64'd1, 64'd0);
         end
         if (mem_wr) wr_cnt++;
      end
   end

   task automatic run(input logic [31:0] base, input bit glitch);
      exp_t e;
      int   n;
      int   cyc;
      n = stim.size();
      for (int k = 0; k < n; k++) begin
         mem[base[11:2] + 10'(k)] = stim[k];
         adr_q.push_back(base + 32'(4 * k));
         if (k == 0 || $signed(stim[k]) > $signed(model_val)) begin
            model_val = stim[k];
            model_idx = 16'(k);
         end
      end
      e.val = model_val;
      e.idx = model_idx;
      e.lat = (n == 0) ? 1 : n + 3;
      e.n   = n;
      exp_q.push_back(e);
      rd_cnt = 0;
      wr_cnt = 0;
      @(negedge clk);
      base_adr = base;
      len      = 16'(n);
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < n + 20) begin
         start    = glitch && (cyc == 2);
         base_adr = glitch ? 32'd0 : base;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("done_seen", 64'(done), 64'd1);
      if (done && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("latency", 64'(cyc), 64'(e.lat));
         check("max_val", 64'(max_val), 64'(e.val));
         check("max_idx", 64'(max_idx), 64'(e.idx));
         check("busy_at_done", 64'(busy), 64'd0);
         check("rd_count", 64'(rd_cnt), 64'(e.n));
         check("wr_count", 64'(wr_cnt), (e.n == 0) ? 64'd0 : 64'd2);
         if (e.n != 0) begin
            check("mem_res_val", 64'(mem[500]), 64'(e.val));
            check("mem_res_idx", 64'(mem[501]), 64'(e.idx));
         end
      end
      stim.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 1024; k++) mem[k] = '0;
      rst      = 1'b1;
      start    = 1'b0;
      base_adr = '0;
      len      = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_max_val", 64'(max_val), 64'd0);
      check("rst_mem_rd", 64'(mem_rd), 64'd0);
      rst = 1'b0;

      // basic run
      stim = '{32'd5, -32'sd3, 32'd17, 32'd2};
      run(32'd1000, 1'b0);

      // all negative, tie, with a start pulse during READ
      stim = '{-32'sd9, -32'sd2, -32'sd2, -32'sd7};
      run(32'd1200, 1'b1);

      // single most-negative element
      stim = '{32'h8000_0000};
      run(32'd1400, 1'b0);

      // empty array: no accesses, results held
      mem[500] = SENTINEL;
      run(32'd1600, 1'b0);
      check("len0_mem_untouched", 64'(mem[500]), 64'(SENTINEL));

      // back-to-back runs
      stim = '{32'd7, 32'd3};
      run(32'd1700, 1'b0);
      stim = '{32'd1, 32'd1, 32'd1};
      run(32'd1800, 1'b0);

      // reset in the middle of a long READ
      mem[500] = SENTINEL;
      mem[501] = SENTINEL;
      for (int k = 0; k < 8; k++) begin
         mem[750 + k] = 32'(100 + k);
         adr_q.push_back(32'd3000 + 32'(4 * k));
      end
      @(negedge clk);
      base_adr = 32'd3000;
      len      = 16'd8;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_mem_rd", 64'(mem_rd), 64'd0);
      check("mid_rst_mem_wr", 64'(mem_wr), 64'd0);
      check("mid_rst_mem_adr", 64'(mem_adr), 64'd0);
      check("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_max_val", 64'(max_val), 64'd0);
      check("mid_rst_max_idx", 64'(max_idx), 64'd0);
      model_val = '0;
      model_idx = '0;
      adr_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("mid_rst_res_val", 64'(mem[500]), 64'(SENTINEL));
      check("mid_rst_res_idx", 64'(mem[501]), 64'(SENTINEL));
      check("mid_rst_idle_busy", 64'(busy), 64'd0);

      // recovery after reset
      stim = '{32'd4, 32'd9, 32'd9, -32'sd1, 32'd8};
      run(32'd1900, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
